// File: rtl/trace_checker_if.sv
// Purpose: bundles the trace_checker's commit stream, golden ROM port and
//          verdict outputs into one interface.
// Ports (signals):
//   commit_*            retired-instruction stream from the core
//   gold_rd/gold_addr   ROM read request; gold_data returns one cycle later
//   done/pass/fail      verdict; fail_field/fail_index locate the first failure
//   checked_cnt         matched entries; overflow flags a lost commit
// Modports: master = core/ROM side (testbench), slave = trace_checker.
interface trace_checker_if #(
  parameter int unsigned GOLD_AW = 11
);
  logic               commit_valid;
  logic [31:0]        commit_pc;
  logic [31:0]        commit_inst;
  logic               commit_we;
  logic [4:0]         commit_waddr;
  logic [31:0]        commit_wdata;

  logic               gold_rd;
  logic [GOLD_AW-1:0] gold_addr;
  logic [127:0]       gold_data;

  logic               done;
  logic               pass;
  logic               fail;
  logic [1:0]         fail_field;
  logic [15:0]        fail_index;
  logic [15:0]        checked_cnt;
  logic               overflow;

  modport master (
    output commit_valid, commit_pc, commit_inst, commit_we, commit_waddr,
           commit_wdata, gold_data,
    input  gold_rd, gold_addr, done, pass, fail, fail_field, fail_index,
           checked_cnt, overflow
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst, commit_we, commit_waddr,
           commit_wdata, gold_data,
    output gold_rd, gold_addr, done, pass, fail, fail_field, fail_index,
           checked_cnt, overflow
  );
endinterface

// File: rtl/trace_checker.sv
// Purpose: on-chip self-check of a commit stream against a golden trace held
//          in an external synchronous ROM; reports pass/fail without a
//          simulator-side register dump.
// Ports:
//   clk_in  system clock, rising edge
//   reset   synchronous active-high reset, highest priority
//   tc      trace_checker_if.slave: commit stream in, ROM read port,
//           verdict/status outputs (all registered)
module trace_checker #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TRACE_LEN  = 2048,
  parameter int unsigned GOLD_AW    = 11,
  parameter logic [31:0] PC_BASE    = 32'h0040_0000
) (
  input  logic            clk_in,
  input  logic            reset,
  trace_checker_if.slave  tc
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = 16;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } commit_t;

  state_t          r_state;
  commit_t         r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [IW-1:0]   r_issue_idx;
  commit_t         r_stage;
  logic            r_stage_vld;
  logic [IW-1:0]   r_stage_idx;
  logic            r_gold_rd;
  logic [GOLD_AW-1:0] r_gold_addr;
  logic            r_done;
  logic            r_pass;
  logic            r_fail;
  logic [1:0]      r_fail_field;
  logic [IW-1:0]   r_fail_index;
  logic [IW-1:0]   r_checked;
  logic            r_overflow;

  commit_t         w_push_data;
  logic            w_norm_we;
  logic            w_run;
  logic            w_push_req;
  logic            w_full;
  logic            w_idx_live;
  logic            w_cmp_vld;
  logic            w_pc_bad;
  logic            w_inst_bad;
  logic            w_wx_bad;
  logic            w_wdata_bad;
  logic            w_mismatch;
  logic            w_match;
  logic [1:0]      w_field;
  logic            w_pop;
  logic            w_drop;
  logic            w_ovf;
  logic            w_push;
  logic [IW-1:0]   w_checked_nxt;
  logic            w_pass_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic            w_issue_nxt;
  logic [25:0]     w_gold_unused;

  // Normalize the commit: rebase PC, drop r0 writes, zero write fields when no write.
  assign w_norm_we         = tc.commit_we && (tc.commit_waddr != 5'd0);
  assign w_push_data.pc    = tc.commit_pc - PC_BASE;
  assign w_push_data.inst  = tc.commit_inst;
  assign w_push_data.we    = w_norm_we;
  assign w_push_data.waddr = w_norm_we ? tc.commit_waddr : 5'd0;
  assign w_push_data.wdata = w_norm_we ? tc.commit_wdata : 32'd0;

  assign w_run       = (r_state == ST_RUN);
  assign w_push_req  = tc.commit_valid && w_run;
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_idx_live  = (r_issue_idx < IW'(TRACE_LEN));

  // Golden word bits [63:38] carry nothing we check.
  assign w_gold_unused = tc.gold_data[63:38];

  // Compare stage: stage register against the ROM word returned this cycle.
  assign w_cmp_vld   = r_stage_vld && w_run;
  assign w_pc_bad    = (r_stage.pc   != tc.gold_data[127:96]);
  assign w_inst_bad  = (r_stage.inst != tc.gold_data[95:64]);
  assign w_wx_bad    = (r_stage.we != tc.gold_data[37]) ||
                       (tc.gold_data[37] && (r_stage.waddr != tc.gold_data[36:32]));
  assign w_wdata_bad = tc.gold_data[37] && (r_stage.wdata != tc.gold_data[31:0]);
  assign w_mismatch  = w_cmp_vld && (w_pc_bad || w_inst_bad || w_wx_bad || w_wdata_bad);
  assign w_match     = w_cmp_vld && !w_mismatch;
  assign w_field     = w_pc_bad   ? 2'd0 :
                       w_inst_bad ? 2'd1 :
                       w_wx_bad   ? 2'd2 : 2'd3;

  // r_gold_rd is the issue strobe for this cycle; a mismatch discards it.
  assign w_pop       = r_gold_rd && w_run && !w_mismatch;
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_ovf       = w_drop && w_idx_live;
  assign w_push      = w_push_req && (!w_full || w_pop);

  assign w_checked_nxt = r_checked + IW'(w_match);
  assign w_pass_nxt    = w_match && (w_checked_nxt == IW'(TRACE_LEN));
  assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
  assign w_idx_nxt     = r_issue_idx + IW'(w_pop);

  // Look one cycle ahead so the ROM strobe leaves a flop in its issue cycle.
  assign w_issue_nxt = w_run && !w_mismatch && !w_ovf && !w_pass_nxt &&
                       (w_count_nxt != '0) && (w_idx_nxt < IW'(TRACE_LEN));

  // Commit buffer storage; pointers live with the control state.
  always_ff @(posedge clk_in) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  // Control: FIFO pointers, issue/compare pipeline, counters and verdict FSM.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_issue_idx  <= '0;
      r_stage      <= '0;
      r_stage_vld  <= 1'b0;
      r_stage_idx  <= '0;
      r_gold_rd    <= 1'b0;
      r_gold_addr  <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_field <= 2'd0;
      r_fail_index <= '0;
      r_checked    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_gold_rd <= w_issue_nxt;
      if (w_run) begin
        r_gold_addr <= GOLD_AW'(w_idx_nxt);
        r_count     <= w_count_nxt;
        r_stage_vld <= w_pop;
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr      <= r_rptr + PW'(1);
          r_issue_idx <= w_idx_nxt;
          r_stage     <= r_mem[r_rptr];
          r_stage_idx <= r_issue_idx;
        end
        if (w_match) begin
          r_checked <= w_checked_nxt;
        end
        if (w_ovf) begin
          r_overflow <= 1'b1;
        end
        case (1'b1)
          w_mismatch: begin
            r_state      <= ST_FAIL;
            r_done       <= 1'b1;
            r_fail       <= 1'b1;
            r_fail_field <= w_field;
            r_fail_index <= r_stage_idx;
          end
          w_ovf: begin
            r_state      <= ST_FAIL;
            r_done       <= 1'b1;
            r_fail       <= 1'b1;
            r_fail_field <= 2'd0;
            r_fail_index <= r_issue_idx + IW'(r_count);
          end
          w_pass_nxt: begin
            r_state <= ST_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign tc.gold_rd     = r_gold_rd;
  assign tc.gold_addr   = r_gold_addr;
  assign tc.done        = r_done;
  assign tc.pass        = r_pass;
  assign tc.fail        = r_fail;
  assign tc.fail_field  = r_fail_field;
  assign tc.fail_index  = r_fail_index;
  assign tc.checked_cnt = r_checked;
  assign tc.overflow    = r_overflow;

endmodule

// File: tb/tb_trace_checker.sv
// Purpose: directed self-checking bench for trace_checker (FIFO_DEPTH=2,
//          TRACE_LEN=4) with a synchronous golden ROM model.
module tb_trace_checker;

  localparam int unsigned GOLD_AW = 2;
  localparam logic [31:0] PC_BASE = 32'h0040_0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [127:0] gold_mem [4];

  trace_checker_if #(.GOLD_AW(GOLD_AW)) tc ();

  trace_checker #(
    .FIFO_DEPTH (2),
    .TRACE_LEN  (4),
    .GOLD_AW    (GOLD_AW),
    .PC_BASE    (PC_BASE)
  ) dut (
    .clk_in (clk),
    .reset  (reset),
    .tc     (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (tc.gold_rd) tc.gold_data <= gold_mem[tc.gold_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic rom_default();
    for (int i = 0; i < 4; i++) begin
      gold_mem[i] = {32'(i * 4), 32'h2001_0000 + 32'(i), 26'd0, 1'b1, 5'(i + 1), 32'h100 + 32'(i)};
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                       input logic [4:0] waddr, input logic [31:0] wdata);
    tc.commit_valid = 1'b1;
    tc.commit_pc    = pc;
    tc.commit_inst  = inst;
    tc.commit_we    = we;
    tc.commit_waddr = waddr;
    tc.commit_wdata = wdata;
  endtask

  task automatic drive_entry(input int i);
    drive(PC_BASE + 32'(i * 4), 32'h2001_0000 + 32'(i), 1'b1, 5'(i + 1), 32'h100 + 32'(i));
  endtask

  task automatic idle();
    tc.commit_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_done"}, 32'(tc.done), 32'd0);
    check_eq({tag, "_pass"}, 32'(tc.pass), 32'd0);
    check_eq({tag, "_fail"}, 32'(tc.fail), 32'd0);
    check_eq({tag, "_ovf"},  32'(tc.overflow), 32'd0);
    check_eq({tag, "_cnt"},  32'(tc.checked_cnt), 32'd0);
    check_eq({tag, "_rd"},   32'(tc.gold_rd), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    tc.gold_data = '0;
    drive(32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    rom_default();

    // Reset held 3 cycles, no commits.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("rst");
    check_eq("rst_ffield", 32'(tc.fail_field), 32'd0);
    check_eq("rst_findex", 32'(tc.fail_index), 32'd0);
    check_eq("rst_addr",   32'(tc.gold_addr), 32'd0);
    repeat (2) @(negedge clk);
    check_quiet("idle");

    // Four back-to-back matching commits.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        check_eq("bb_rd",   32'(tc.gold_rd), 32'd1);
        check_eq("bb_addr", 32'(tc.gold_addr), 32'(i - 1));
      end
      drive_entry(i);
      @(negedge clk);
    end
    idle();
    check_eq("bb_rd3",   32'(tc.gold_rd), 32'd1);
    check_eq("bb_addr3", 32'(tc.gold_addr), 32'd3);
    @(negedge clk);
    check_eq("bb_rd_off", 32'(tc.gold_rd), 32'd0);
    check_eq("bb_cnt3",   32'(tc.checked_cnt), 32'd3);
    check_eq("bb_pass_early", 32'(tc.pass), 32'd0);
    @(negedge clk);
    check_eq("bb_pass", 32'(tc.pass), 32'd1);
    check_eq("bb_done", 32'(tc.done), 32'd1);
    check_eq("bb_fail", 32'(tc.fail), 32'd0);
    check_eq("bb_cnt",  32'(tc.checked_cnt), 32'd4);
    drive_entry(0);
    @(negedge clk);
    idle();
    check_eq("pass_frozen_rd", 32'(tc.gold_rd), 32'd0);

    // Instruction mismatch on entry 2.
    gold_mem[2][95:64] = 32'h2001_0001;
    apply_reset();
    check_quiet("rst2");
    for (int i = 0; i < 4; i++) begin
      drive_entry(i);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    check_eq("inst_fail",   32'(tc.fail), 32'd1);
    check_eq("inst_done",   32'(tc.done), 32'd1);
    check_eq("inst_pass",   32'(tc.pass), 32'd0);
    check_eq("inst_field",  32'(tc.fail_field), 32'd1);
    check_eq("inst_index",  32'(tc.fail_index), 32'd2);
    check_eq("inst_cnt",    32'(tc.checked_cnt), 32'd2);
    check_eq("inst_rd_off", 32'(tc.gold_rd), 32'd0);
    drive_entry(3);
    repeat (3) @(negedge clk);
    idle();
    check_eq("inst_cnt_frozen", 32'(tc.checked_cnt), 32'd2);
    check_eq("inst_rd_frozen",  32'(tc.gold_rd), 32'd0);
    check_eq("inst_idx_frozen", 32'(tc.fail_index), 32'd2);

    // r0 write normalizes to no-write; wdata mismatch on entry 1.
    rom_default();
    gold_mem[0] = {32'd0, 32'h2001_0000, 26'd0, 1'b0, 5'd0, 32'd0};
    gold_mem[1] = {32'd4, 32'h2001_0001, 26'd0, 1'b1, 5'd8, 32'd6};
    apply_reset();
    drive(PC_BASE, 32'h2001_0000, 1'b1, 5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(PC_BASE + 32'd4, 32'h2001_0001, 1'b1, 5'd8, 32'd5);
    @(negedge clk);
    idle();
    @(negedge clk);
    check_eq("r0_cnt",  32'(tc.checked_cnt), 32'd1);
    check_eq("r0_fail", 32'(tc.fail), 32'd0);
    @(negedge clk);
    check_eq("wd_fail",  32'(tc.fail), 32'd1);
    check_eq("wd_field", 32'(tc.fail_field), 32'd3);
    check_eq("wd_index", 32'(tc.fail_index), 32'd1);
    check_eq("wd_cnt",   32'(tc.checked_cnt), 32'd1);

    // Reset mid-run with entry 1 in flight, then a fresh run from address 0.
    rom_default();
    apply_reset();
    drive_entry(0);
    @(negedge clk);
    drive_entry(1);
    check_eq("mid_addr0", 32'(tc.gold_addr), 32'd0);
    @(negedge clk);
    idle();
    check_eq("mid_rd1",   32'(tc.gold_rd), 32'd1);
    check_eq("mid_addr1", 32'(tc.gold_addr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_quiet("mid");
    check_eq("mid_addr_rst", 32'(tc.gold_addr), 32'd0);
    drive_entry(0);
    @(negedge clk);
    idle();
    check_eq("mid_restart_rd",   32'(tc.gold_rd), 32'd1);
    check_eq("mid_restart_addr", 32'(tc.gold_addr), 32'd0);
    @(negedge clk);
    check_eq("mid_restart_rd_off", 32'(tc.gold_rd), 32'd0);
    @(negedge clk);
    check_eq("mid_restart_cnt", 32'(tc.checked_cnt), 32'd1);

    // Overflow: issue held off, three commits into a two-entry FIFO.
    apply_reset();
    force dut.r_gold_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_entry(i);
      @(negedge clk);
    end
    idle();
    release dut.r_gold_rd;
    check_eq("ovf_flag",  32'(tc.overflow), 32'd1);
    check_eq("ovf_fail",  32'(tc.fail), 32'd1);
    check_eq("ovf_done",  32'(tc.done), 32'd1);
    check_eq("ovf_pass",  32'(tc.pass), 32'd0);
    check_eq("ovf_field", 32'(tc.fail_field), 32'd0);
    check_eq("ovf_index", 32'(tc.fail_index), 32'd2);
    check_eq("ovf_cnt",   32'(tc.checked_cnt), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("ovf_rd_off", 32'(tc.gold_rd), 32'd0);
    check_eq("ovf_sticky", 32'(tc.overflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Synthesizable self-check stage sitting directly downstream of sccomp_dataflow.
- Consumes the per-instruction commit stream: PC, instruction, and register-file write.
- Compares each commit against a golden trace held in an external synchronous ROM, one golden entry per instruction.
- Reports pass/fail on-chip, so board runs need no simulator-side register dump.

Parameters:
- FIFO_DEPTH, 8, commit buffer entries; power of two, ≥2.
- TRACE_LEN, 2048, number of commits to check before declaring pass.
- GOLD_AW, 11, golden ROM address width; 2^GOLD_AW ≥ TRACE_LEN.
- PC_BASE, 32'h00400000, subtracted from commit_pc before comparison.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- commit_valid  input  1  one instruction retired this cycle.
- commit_pc  input  32  PC of retired instruction.
- commit_inst  input  32  retired instruction word.
- commit_we  input  1  register-file write enable.
- commit_waddr  input  5  destination register.
- commit_wdata  input  32  write data.
- gold_rd  output  1  ROM read strobe.
- gold_addr  output  GOLD_AW  ROM entry index.
- gold_data  input  128  ROM data, valid exactly 1 cycle after gold_rd.
- done  output  1  checking finished (pass or fail).
- pass  output  1  all TRACE_LEN entries matched.
- fail  output  1  mismatch or overflow.
- fail_field  output  2  0 pc, 1 inst, 2 we/waddr, 3 wdata.
- fail_index  output  16  entry index of first failure.
- checked_cnt  output  16  entries compared and matched.
- overflow  output  1  commit lost because FIFO was full.

Behaviour:
- Reset (sync, active-high, highest priority, also mid-run): FIFO empty, pointers 0, all outputs 0, FSM in RUN.
- Commit normalization on push:
  - Store pc = commit_pc − PC_BASE (mod 2^32).
  - If commit_we=1 and commit_waddr=0, store we=0 (r0 writes are not architectural).
  - When stored we=0, waddr and wdata are stored as 0.
- FIFO:
  - Push when commit_valid && state==RUN.
  - Simultaneous push and pop is legal when full or empty (empty: the pop is not issued).
  - Push while full with no pop in the same cycle: drop the commit, set overflow (sticky), enter FAIL with fail_field=0, fail_index=entry count at drop.
- Golden word layout:
  - [127:96] pc offset, [95:64] inst.
  - [37] we, [36:32] waddr, [31:0] wdata.
  - [63:38] ignored.
- Issue stage (cycle t): in RUN, FIFO non-empty, and issue_idx<TRACE_LEN:
  - gold_rd=1, gold_addr=issue_idx[GOLD_AW-1:0].
  - Pop FIFO head into a stage register; issue_idx++.
- Compare stage (cycle t+1): stage register vs gold_data.
  - Field priority pc > inst > we/waddr > wdata.
  - waddr and wdata are compared only when golden we=1.
  - Match: checked_cnt++.
  - Mismatch: FAIL; latch fail_field and fail_index = stage index.
  - An issue in the same cycle as a mismatch is discarded; checked_cnt is not incremented.
- Throughput 1 entry/cycle; commit-to-verdict latency 2 cycles when the FIFO is empty.
- FSM states:
  - RUN → PASS when checked_cnt reaches TRACE_LEN.
  - RUN → FAIL on mismatch or overflow.
  - PASS and FAIL are terminal until reset.
- Terminal states:
  - PASS: done=1, pass=1. FAIL: done=1, fail=1.
  - Commits ignored, gold_rd=0, all counters and fail fields frozen.
- Commits beyond TRACE_LEN: not issued; FIFO may fill.
  - Overflow is not flagged once issue_idx==TRACE_LEN.
- Outputs are registered; pass and fail are never both 1.

Test Plan:
- Reset held 3 cycles then released, no commits → all outputs 0, gold_rd=0, state RUN.
- TRACE_LEN=4, four back-to-back matching commits (pc 0x00400000..0x0040000C, ROM mirrors) → gold_rd high 4 consecutive cycles, addr 0..3; checked_cnt=4; pass=1 and done=1 two cycles after last commit.
- Entry 2 ROM inst=0x20010001, commit inst=0x20010002 → fail=1, fail_field=1, fail_index=2, checked_cnt=2; later commits ignored.
- Commit we=1, waddr=0, wdata=0xDEADBEEF vs golden we=0 → match. Commit we=1, waddr=8, wdata=5 vs golden wdata=6 → fail_field=3.
- FIFO_DEPTH=2, ROM gold_data checked but issue blocked by forcing TRACE_LEN reached = false via reset mid-run: assert reset while 1 entry is in flight → next cycle all outputs 0, FIFO empty, a fresh run restarts at gold_addr 0.
- Overflow: hold issue off with the FIFO full (FIFO_DEPTH=2, 3 commits in the cycles before the first issue, forced via a bench-stalled start) → overflow=1, fail=1, fail_field=0, fail_index=2.
